// File: rtl/frame_capture_pkg.sv
// Shared types and constants for the frame capture block.
package frame_capture_pkg;

    typedef enum logic {
        SEEK    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    localparam int ERR_COUNT_BITS = 8;

    // Adds 0..3 error events to the counter, clamping at all-ones.
    function automatic logic [ERR_COUNT_BITS-1:0] sat_add(
        input logic [ERR_COUNT_BITS-1:0] count,
        input logic [1:0]                inc
    );
        logic [ERR_COUNT_BITS:0] sum;
        sum = {1'b0, count} + (ERR_COUNT_BITS + 1)'(inc);
        return sum[ERR_COUNT_BITS] ? '1 : sum[ERR_COUNT_BITS-1:0];
    endfunction

endpackage

// File: rtl/frame_capture_if.sv
// Pixel stream input and framebuffer write port of the frame capture block.
// master: the environment (pixel source plus memory); slave: frame_capture.
interface frame_capture_if #(
    parameter int PIXEL_BITS = 8,
    parameter int ADDR_BITS  = 7
);
    logic                  in_valid;
    logic                  in_ready;
    logic [PIXEL_BITS-1:0] in_data;
    logic                  in_sof;
    logic                  in_eol;
    logic                  wr_en;
    logic [ADDR_BITS-1:0]  wr_addr;
    logic [PIXEL_BITS-1:0] wr_data;
    logic                  wr_ready;

    modport master (
        output in_valid, in_data, in_sof, in_eol, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data, in_sof, in_eol, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/fc_write_buffer.sv
// One-entry register slice in front of the framebuffer write port.
// The entry can be refilled in the same cycle it drains, so a steady
// stream with wr_ready high runs at one write per clock.
module fc_write_buffer #(
    parameter int ADDR_BITS  = 7,
    parameter int PIXEL_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [PIXEL_BITS-1:0] data,
    input  logic                  wr_ready,
    output logic                  wr_en,
    output logic [ADDR_BITS-1:0]  wr_addr,
    output logic [PIXEL_BITS-1:0] wr_data,
    output logic                  ready
);

    // Space is available when the slot is empty or draining this cycle.
    always_comb begin
        ready = !wr_en || wr_ready;
    end

    // Hold the pending write until it transfers; reload on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (load) begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= data;
        end else if (wr_ready) begin
            wr_en   <= 1'b0;
        end
    end

endmodule

// File: rtl/frame_capture.sv
// Frame capture: recovers x/y of each streamed pixel, checks line and
// frame geometry, and writes pixels to the framebuffer at y*WIDTH+x
// using a running line base instead of a multiplier.
module frame_capture
    import frame_capture_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int HEIGHT     = 10,
    parameter int PIXEL_BITS = 8,
    parameter int X_BITS     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int Y_BITS     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    parameter int ADDR_BITS  = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    frame_capture_if.slave            bus,
    output logic [X_BITS-1:0]         cur_x,
    output logic [Y_BITS-1:0]         cur_y,
    output logic                      frame_done,
    output logic                      err_line,
    output logic                      err_sof,
    output logic [ERR_COUNT_BITS-1:0] err_count
);

    localparam logic [X_BITS-1:0]    X_LAST     = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0]    Y_LAST     = Y_BITS'(HEIGHT - 1);
    localparam logic [ADDR_BITS-1:0] LINE_STEP  = ADDR_BITS'(WIDTH);

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_BITS-1:0]    line_base;
    logic [ADDR_BITS-1:0]    base_next;
    logic [X_BITS-1:0]       x_next;
    logic [Y_BITS-1:0]       y_next;
    logic                    done_next;
    logic                    err_line_next;
    logic                    err_sof_next;
    logic [ERR_COUNT_BITS-1:0] count_next;

    logic                    accept;
    logic                    take;
    logic [X_BITS-1:0]       eff_x;
    logic [Y_BITS-1:0]       eff_y;
    logic [ADDR_BITS-1:0]    eff_base;
    logic                    at_last_x;
    logic                    line_end;
    logic                    line_err;
    logic                    sof_err;
    logic                    frame_end;
    logic [ADDR_BITS-1:0]    load_addr;

    // Beat position and geometry checks; a sof beat is always treated as
    // pixel (0,0), which covers both frame start and mid-frame restart.
    always_comb begin
        accept    = bus.in_valid && bus.in_ready;
        take      = accept && ((state == CAPTURE) || bus.in_sof);
        eff_x     = bus.in_sof ? '0 : cur_x;
        eff_y     = bus.in_sof ? '0 : cur_y;
        eff_base  = bus.in_sof ? '0 : line_base;
        sof_err   = (state == CAPTURE) && bus.in_sof &&
                    ((cur_x != '0) || (cur_y != '0));
        at_last_x = (eff_x == X_LAST);
        line_end  = bus.in_eol || at_last_x;
        line_err  = bus.in_eol != at_last_x;
        frame_end = line_end && (eff_y == Y_LAST);
        load_addr = eff_base + ADDR_BITS'(eff_x);
    end

    // Next state, position, line base, pulses and error count.
    always_comb begin
        state_next    = state;
        x_next        = cur_x;
        y_next        = cur_y;
        base_next     = line_base;
        done_next     = 1'b0;
        err_line_next = 1'b0;
        err_sof_next  = 1'b0;
        if (take) begin
            err_line_next = line_err;
            err_sof_next  = sof_err;
            if (frame_end) begin
                state_next = SEEK;
                x_next     = '0;
                y_next     = '0;
                base_next  = '0;
                done_next  = 1'b1;
            end else if (line_end) begin
                state_next = CAPTURE;
                x_next     = '0;
                y_next     = eff_y + Y_BITS'(1);
                base_next  = eff_base + LINE_STEP;
            end else begin
                state_next = CAPTURE;
                x_next     = eff_x + X_BITS'(1);
                y_next     = eff_y;
                base_next  = eff_base;
            end
        end
        count_next = sat_add(err_count, {1'b0, err_line_next} + {1'b0, err_sof_next});
    end

    // State, position and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SEEK;
            cur_x      <= '0;
            cur_y      <= '0;
            line_base  <= '0;
            frame_done <= 1'b0;
            err_line   <= 1'b0;
            err_sof    <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_next;
            cur_x      <= x_next;
            cur_y      <= y_next;
            line_base  <= base_next;
            frame_done <= done_next;
            err_line   <= err_line_next;
            err_sof    <= err_sof_next;
            err_count  <= count_next;
        end
    end

    fc_write_buffer #(
        .ADDR_BITS  (ADDR_BITS),
        .PIXEL_BITS (PIXEL_BITS)
    ) u_write_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (take),
        .addr     (load_addr),
        .data     (bus.in_data),
        .wr_ready (bus.wr_ready),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .wr_data  (bus.wr_data),
        .ready    (bus.in_ready)
    );

endmodule

// File: tb/tb_frame_capture.sv
// Self-checking bench for frame_capture with a 4x3 frame.
module tb_frame_capture;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PB = 8;
    localparam int AB = 4;
    localparam int XB = 2;
    localparam int YB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [XB-1:0] cur_x;
    logic [YB-1:0] cur_y;
    logic          frame_done;
    logic          err_line;
    logic          err_sof;
    logic [7:0]    err_count;

    frame_capture_if #(.PIXEL_BITS(PB), .ADDR_BITS(AB)) bus ();

    frame_capture #(
        .WIDTH(W), .HEIGHT(H), .PIXEL_BITS(PB),
        .X_BITS(XB), .Y_BITS(YB), .ADDR_BITS(AB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .cur_x(cur_x), .cur_y(cur_y), .frame_done(frame_done),
        .err_line(err_line), .err_sof(err_sof), .err_count(err_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame position and expected events.
    bit m_in_frame;
    int m_x, m_y, m_err;
    int exp_wr[$];
    int exp_fd, exp_el, exp_es;

    // Observations gathered while stepping.
    int obs_wr[$];
    int obs_fd, obs_el, obs_es, ready_bad, hold_bad;
    bit hold_armed;
    logic [AB-1:0] hold_addr;
    logic [PB-1:0] hold_data;

    task automatic model_reset();
        m_in_frame = 0; m_x = 0; m_y = 0; m_err = 0;
        hold_armed = 0;
        exp_wr.delete(); obs_wr.delete();
    endtask

    task automatic clear_sb();
        exp_wr.delete(); obs_wr.delete();
        exp_fd = 0; exp_el = 0; exp_es = 0;
        obs_fd = 0; obs_el = 0; obs_es = 0;
        ready_bad = 0; hold_bad = 0;
    endtask

    task automatic model_beat(input logic [PB-1:0] d, input bit s, input bit e);
        int errs;
        errs = 0;
        if (!m_in_frame) begin
            if (!s) return;
            m_in_frame = 1; m_x = 0; m_y = 0;
        end else if (s && (m_x != 0 || m_y != 0)) begin
            exp_es++; errs++; m_x = 0; m_y = 0;
        end
        exp_wr.push_back(((m_y * W + m_x) << PB) | int'(d));
        if (e != (m_x == W - 1)) begin exp_el++; errs++; end
        if (e || m_x == W - 1) begin
            if (m_y == H - 1) begin exp_fd++; m_in_frame = 0; m_x = 0; m_y = 0; end
            else begin m_x = 0; m_y++; end
        end else begin
            m_x++;
        end
        m_err = (m_err + errs > 255) ? 255 : m_err + errs;
    endtask

    // One clock: drive at negedge, observe handshake, then outputs after posedge.
    task automatic step(input bit v, input logic [PB-1:0] d, input bit s, input bit e,
                        input bit wr, output bit acc);
        @(negedge clk);
        bus.in_valid = v; bus.in_data = d; bus.in_sof = s; bus.in_eol = e; bus.wr_ready = wr;
        #1;
        if (bus.in_ready !== (!bus.wr_en || wr)) ready_bad++;
        if (hold_armed && (bus.wr_en !== 1'b1 || bus.wr_addr !== hold_addr || bus.wr_data !== hold_data))
            hold_bad++;
        hold_armed = bus.wr_en && !wr;
        hold_addr  = bus.wr_addr;
        hold_data  = bus.wr_data;
        acc = v && bus.in_ready;
        if (bus.wr_en && wr) obs_wr.push_back(int'({bus.wr_addr, bus.wr_data}));
        if (acc) model_beat(d, s, e);
        @(posedge clk);
        #1;
        if (frame_done) obs_fd++;
        if (err_line) obs_el++;
        if (err_sof) obs_es++;
    endtask

    task automatic send(input logic [PB-1:0] d, input bit s, input bit e, input bit wr);
        bit acc;
        int tries;
        tries = 0;
        do begin
            step(1'b1, d, s, e, wr, acc);
            tries++;
        end while (!acc && tries < 20);
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: beat not accepted after %0d cycles", tries);
        end
    endtask

    task automatic drain();
        bit acc;
        repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 0; bus.in_data = '0; bus.in_sof = 0; bus.in_eol = 0; bus.wr_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
        n_cmp++; if (bus.wr_addr !== 4'd0 || bus.wr_data !== 8'd0) begin n_bad++; $display("FAIL reset_wr_bus: got %0d/%0d want 0/0", bus.wr_addr, bus.wr_data); end
        n_cmp++; if (cur_x !== 2'd0 || cur_y !== 2'd0) begin n_bad++; $display("FAIL reset_pos: got (%0d,%0d) want (0,0)", cur_x, cur_y); end
        n_cmp++; if ({frame_done, err_line, err_sof} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {frame_done, err_line, err_sof}); end
        n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_clean_frame();
        clear_sb();
        for (int i = 0; i < W * H; i++) begin
            send(PB'(i), i == 0, (i % W) == W - 1, 1'b1);
            n_cmp++;
            if (frame_done !== (i == W * H - 1)) begin n_bad++; $display("FAIL clean_frame_done beat %0d: got %b want %b", i, frame_done, i == W * H - 1); end
        end
        drain();
        n_cmp++;
        if (obs_wr.size() != W * H) begin n_bad++; $display("FAIL clean_write_count: got %0d want %0d", obs_wr.size(), W * H); end
        else for (int i = 0; i < W * H; i++) begin
            n_cmp++;
            if (obs_wr[i] !== ((i << PB) | i)) begin n_bad++; $display("FAIL clean_write %0d: got addr %0d data %0d want %0d/%0d", i, obs_wr[i] >> PB, obs_wr[i] & 255, i, i); end
        end
        n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL clean_err_count: got %0d want 0", err_count); end
        n_cmp++; if (cur_x !== 2'd0 || cur_y !== 2'd0) begin n_bad++; $display("FAIL clean_end_pos: got (%0d,%0d) want (0,0)", cur_x, cur_y); end
    endtask

    task automatic test_seek();
        bit acc;
        int bad;
        clear_sb();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, PB'($urandom_range(255)), 1'b0, i == 2, 1'b1, acc);
            n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL seek_accept %0d: got %b want 1", i, acc); end
        end
        drain();
        n_cmp++; if (obs_wr.size() != 0 || err_count !== 8'd0) begin n_bad++; $display("FAIL seek_dropped: got %0d writes err %0d want 0/0", obs_wr.size(), err_count); end
        for (int i = 0; i < W * H; i++) send(PB'($urandom_range(255)), i == 0, (i % W) == W - 1, 1'b1);
        drain();
        bad = (obs_wr.size() != exp_wr.size());
        if (!bad) foreach (exp_wr[i]) if (obs_wr[i] !== exp_wr[i]) bad = 1;
        n_cmp++; if (bad) begin n_bad++; $display("FAIL seek_writes: got %0d writes want %0d (or contents differ)", obs_wr.size(), exp_wr.size()); end
        n_cmp++; if (obs_wr.size() == 0 || (obs_wr[0] >> PB) !== 0) begin n_bad++; $display("FAIL seek_first_addr: want first write at addr 0"); end
    endtask

    task automatic test_early_eol();
        int bad;
        clear_sb();
        for (int i = 0; i < 3; i++) begin
            send(PB'($urandom_range(255)), i == 0, i == 2, 1'b1);
            n_cmp++; if (err_line !== (i == 2)) begin n_bad++; $display("FAIL early_eol_pulse beat %0d: got %b want %b", i, err_line, i == 2); end
        end
        n_cmp++; if (cur_x !== 2'd0 || cur_y !== 2'd1) begin n_bad++; $display("FAIL early_eol_pos: got (%0d,%0d) want (0,1)", cur_x, cur_y); end
        for (int i = 0; i < 2 * W; i++) send(PB'($urandom_range(255)), 1'b0, (i % W) == W - 1, 1'b1);
        drain();
        bad = (obs_wr.size() != exp_wr.size());
        if (!bad) foreach (exp_wr[i]) if (obs_wr[i] !== exp_wr[i]) bad = 1;
        n_cmp++; if (bad) begin n_bad++; $display("FAIL early_eol_writes: got %0d writes want %0d (or contents differ)", obs_wr.size(), exp_wr.size()); end
        n_cmp++; if (obs_wr.size() < 4 || (obs_wr[3] >> PB) !== 4) begin n_bad++; $display("FAIL early_eol_next_addr: want 4th write at addr 4"); end
        n_cmp++; if (obs_fd !== 1 || obs_wr.size() != 11) begin n_bad++; $display("FAIL early_eol_done: got %0d done / %0d writes want 1/11", obs_fd, obs_wr.size()); end
        n_cmp++; if (err_count !== 8'(m_err)) begin n_bad++; $display("FAIL early_eol_err_count: got %0d want %0d", err_count, m_err); end
    endtask

    task automatic test_mid_sof();
        int bad;
        int guard;
        clear_sb();
        for (int i = 0; i < 6; i++) send(PB'($urandom_range(255)), i == 0, i == W - 1, 1'b1);
        send(8'hA5, 1'b1, 1'b0, 1'b1);
        n_cmp++; if (err_sof !== 1'b1 || err_line !== 1'b0) begin n_bad++; $display("FAIL mid_sof_pulse: got sof %b line %b want 1/0", err_sof, err_line); end
        n_cmp++; if (cur_x !== 2'd1 || cur_y !== 2'd0) begin n_bad++; $display("FAIL mid_sof_pos: got (%0d,%0d) want (1,0)", cur_x, cur_y); end
        guard = 0;
        while (m_in_frame && guard < 20) begin
            send(PB'($urandom_range(255)), 1'b0, m_x == W - 1, 1'b1);
            guard++;
        end
        drain();
        n_cmp++; if (obs_wr.size() < 7 || obs_wr[6] !== 'hA5) begin n_bad++; $display("FAIL mid_sof_addr: want 7th write addr 0 data a5"); end
        bad = (obs_wr.size() != exp_wr.size());
        if (!bad) foreach (exp_wr[i]) if (obs_wr[i] !== exp_wr[i]) bad = 1;
        n_cmp++; if (bad) begin n_bad++; $display("FAIL mid_sof_writes: got %0d writes want %0d (or contents differ)", obs_wr.size(), exp_wr.size()); end
        n_cmp++; if (obs_fd !== exp_fd || obs_es !== 1) begin n_bad++; $display("FAIL mid_sof_events: got done %0d sof_err %0d want %0d/1", obs_fd, obs_es, exp_fd); end
    endtask

    task automatic test_back_pressure();
        logic [PB-1:0] dat[W * H];
        bit acc, wr;
        int k, late_miss, bad;
        clear_sb();
        foreach (dat[i]) dat[i] = PB'($urandom_range(255));
        k = 0; late_miss = 0;
        for (int c = 0; c < 40 && k < W * H; c++) begin
            wr = !(c >= 2 && c <= 4);
            step(1'b1, dat[k], k == 0, (k % W) == W - 1, wr, acc);
            if (!wr) begin
                n_cmp++; if (acc !== 1'b0) begin n_bad++; $display("FAIL bp_stall_accept c%0d: got %b want 0", c, acc); end
                n_cmp++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'd1 || bus.wr_data !== dat[1]) begin n_bad++; $display("FAIL bp_hold c%0d: got en %b addr %0d data %0d want 1/1/%0d", c, bus.wr_en, bus.wr_addr, bus.wr_data, dat[1]); end
            end else if (c >= 5 && !acc) begin
                late_miss++;
            end
            if (acc) k++;
        end
        drain();
        n_cmp++; if (k !== W * H || late_miss !== 0) begin n_bad++; $display("FAIL bp_throughput: got %0d beats %0d bubbles want %0d/0", k, late_miss, W * H); end
        bad = (obs_wr.size() != exp_wr.size());
        if (!bad) foreach (exp_wr[i]) if (obs_wr[i] !== exp_wr[i]) bad = 1;
        n_cmp++; if (bad) begin n_bad++; $display("FAIL bp_writes: got %0d writes want %0d (or contents differ)", obs_wr.size(), exp_wr.size()); end
        n_cmp++; if (ready_bad !== 0 || hold_bad !== 0) begin n_bad++; $display("FAIL bp_rules: got ready_bad %0d hold_bad %0d want 0/0", ready_bad, hold_bad); end
    endtask

    task automatic test_random();
        bit acc, v, wr, s, e;
        int bad;
        clear_sb();
        for (int c = 0; c < 700; c++) begin
            v  = ($urandom_range(3) != 0);
            wr = ($urandom_range(9) < 7);
            if (!m_in_frame) s = ($urandom_range(2) == 0);
            else s = ($urandom_range(29) == 0);
            e = (m_x == W - 1);
            if (m_in_frame && $urandom_range(14) == 0) e = !e;
            step(v, PB'($urandom_range(255)), s, e, wr, acc);
        end
        drain();
        bad = (obs_wr.size() != exp_wr.size());
        if (!bad) foreach (exp_wr[i]) if (obs_wr[i] !== exp_wr[i]) bad = 1;
        n_cmp++; if (bad) begin n_bad++; $display("FAIL rand_writes: got %0d writes want %0d (or contents differ)", obs_wr.size(), exp_wr.size()); end
        n_cmp++; if (obs_fd !== exp_fd || obs_el !== exp_el || obs_es !== exp_es) begin n_bad++; $display("FAIL rand_events: got %0d/%0d/%0d want %0d/%0d/%0d", obs_fd, obs_el, obs_es, exp_fd, exp_el, exp_es); end
        n_cmp++; if (err_count !== 8'(m_err)) begin n_bad++; $display("FAIL rand_err_count: got %0d want %0d", err_count, m_err); end
        n_cmp++; if (cur_x !== XB'(m_x) || cur_y !== YB'(m_y)) begin n_bad++; $display("FAIL rand_pos: got (%0d,%0d) want (%0d,%0d)", cur_x, cur_y, m_x, m_y); end
        n_cmp++; if (ready_bad !== 0 || hold_bad !== 0) begin n_bad++; $display("FAIL rand_rules: got ready_bad %0d hold_bad %0d want 0/0", ready_bad, hold_bad); end
    endtask

    task automatic test_err_saturate();
        int guard;
        clear_sb();
        send(PB'($urandom_range(255)), 1'b1, 1'b0, 1'b1);
        send(PB'($urandom_range(255)), 1'b1, 1'b1, 1'b1);
        n_cmp++; if (err_sof !== 1'b1 || err_line !== 1'b1) begin n_bad++; $display("FAIL sat_double_pulse: got sof %b line %b want 1/1", err_sof, err_line); end
        n_cmp++; if (err_count !== 8'(m_err)) begin n_bad++; $display("FAIL sat_double_count: got %0d want %0d", err_count, m_err); end
        repeat (130) send(PB'($urandom_range(255)), 1'b1, 1'b1, 1'b1);
        n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL sat_count: got %0d want 255", err_count); end
        guard = 0;
        while (m_in_frame && guard < 20) begin
            send(PB'($urandom_range(255)), 1'b0, m_x == W - 1, 1'b1);
            guard++;
        end
        drain();
        n_cmp++; if (err_count !== 8'd255 || obs_fd !== 1) begin n_bad++; $display("FAIL sat_hold: got count %0d done %0d want 255/1", err_count, obs_fd); end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        clear_sb();
        for (int i = 0; i < W + 2; i++) send(PB'($urandom_range(255)), i == 0, i == W - 1, 1'b1);
        n_cmp++; if (cur_x !== 2'd2 || cur_y !== 2'd1 || bus.wr_en !== 1'b1) begin n_bad++; $display("FAIL rmf_setup: got (%0d,%0d) wr_en %b want (2,1) 1", cur_x, cur_y, bus.wr_en); end
        @(negedge clk);
        rst_n = 1'b0; bus.in_valid = 0; bus.wr_ready = 0;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.wr_en !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rmf_wr: got wr_en %b in_ready %b want 0/1", bus.wr_en, bus.in_ready); end
        n_cmp++; if (bus.wr_addr !== 4'd0 || bus.wr_data !== 8'd0) begin n_bad++; $display("FAIL rmf_wr_bus: got %0d/%0d want 0/0", bus.wr_addr, bus.wr_data); end
        n_cmp++; if (cur_x !== 2'd0 || cur_y !== 2'd0 || err_count !== 8'd0) begin n_bad++; $display("FAIL rmf_state: got (%0d,%0d) err %0d want (0,0) 0", cur_x, cur_y, err_count); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_sb();
        send(PB'($urandom_range(255)), 1'b0, 1'b0, 1'b1);
        drain();
        n_cmp++; if (obs_wr.size() != 0) begin n_bad++; $display("FAIL rmf_seek: got %0d writes want 0", obs_wr.size()); end
        for (int i = 0; i < W * H; i++) send(PB'($urandom_range(255)), i == 0, (i % W) == W - 1, 1'b1);
        drain();
        bad = (obs_wr.size() != exp_wr.size());
        if (!bad) foreach (exp_wr[i]) if (obs_wr[i] !== exp_wr[i]) bad = 1;
        n_cmp++; if (bad) begin n_bad++; $display("FAIL rmf_frame: got %0d writes want %0d (or contents differ)", obs_wr.size(), exp_wr.size()); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_clean_frame();
        test_seek();
        test_early_eol();
        test_mid_sof();
        test_back_pressure();
        test_random();
        test_err_saturate();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_capture.md
# frame_capture

Receiving end of the raster pixel stream: accepts pixels over a valid/ready handshake with start-of-frame and end-of-line markers, recovers each pixel's x/y position, and writes it into a framebuffer write port at address y*WIDTH+x. It sits between a scan-driven pixel source and framebuffer memory. It checks line and frame geometry, recovers from malformed streams, and absorbs memory back-pressure through a one-entry write buffer.

## Interface
- WIDTH, 10: pixels per line
- HEIGHT, 10: lines per frame
- PIXEL_BITS, 8: pixel data width
- X_BITS, $clog2(WIDTH): x coordinate width
- Y_BITS, $clog2(HEIGHT): y coordinate width
- ADDR_BITS, $clog2(WIDTH*HEIGHT): framebuffer address width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  source has a beat
- in_ready  out  1  block can take a beat; a beat transfers when in_valid && in_ready
- in_data  in  PIXEL_BITS  pixel value
- in_sof  in  1  beat is pixel (0,0) of a frame
- in_eol  in  1  beat is the last pixel of its line
- wr_en  out  1  write request pending
- wr_addr  out  ADDR_BITS  framebuffer address
- wr_data  out  PIXEL_BITS  framebuffer data
- wr_ready  in  1  memory accepts write this cycle (transfers when wr_en && wr_ready)
- cur_x  out  X_BITS  x of next expected beat
- cur_y  out  Y_BITS  y of next expected beat
- frame_done  out  1  one-cycle pulse, last pixel of frame accepted
- err_line  out  1  one-cycle pulse, eol mismatch
- err_sof  out  1  one-cycle pulse, sof mid-frame
- err_count  out  8  saturating count of all error events

## Operation
- States: SEEK, CAPTURE.
- SEEK: accepted beats with in_sof=0 are dropped, with no write and no error. An accepted beat with in_sof=1 is written at (0,0), and the block moves to CAPTURE with the next position (1,0).
- CAPTURE: every accepted beat is written at line_base + cur_x. line_base is a register stepped by +WIDTH per line; no multiplier.
- End of line: cur_x resets to 0, cur_y increments, and line_base += WIDTH.
- in_eol=1 with cur_x==WIDTH-1: normal end of line.
- in_eol=1 with cur_x<WIDTH-1: err_line pulses, the pixel is written, and the line ends early. Missing pixels are not written.
- in_eol=0 with cur_x==WIDTH-1: err_line pulses, the pixel is written, and the line ends anyway.
- Last pixel: when the line-ending beat is accepted at cur_y==HEIGHT-1, frame_done pulses, the block returns to SEEK, and the position is cleared to (0,0). Any accompanying line error still pulses in the same cycle.
- in_sof=1 in CAPTURE at any position other than (0,0): err_sof pulses, the beat is written at address 0, the position becomes (1,0), line_base becomes 0, and the block stays in CAPTURE. All eol checks for that beat apply as at x=0.
- err_count adds the number of error pulses this cycle (0..2) and saturates at 255.
- WIDTH==1: every beat is both line start and line end.

## Timing
- in_ready = !wr_en || wr_ready, in both states. It is combinational from registered wr_en and input wr_ready.
- Write latency is 1: a beat accepted at edge N drives wr_en/wr_addr/wr_data from edge N onward.
- wr_en, wr_addr and wr_data are held stable until the write transfers.
- If a beat is accepted while the pending write is completing, the buffer reloads with no bubble, giving full throughput.
- cur_x, cur_y, frame_done, err_* and the state update on the edge that accepts the beat.
- Reset values: state SEEK, in_ready 1, wr_en 0, wr_addr 0, wr_data 0, cur_x 0, cur_y 0, frame_done 0, err_line 0, err_sof 0, err_count 0.
- Reset mid-operation drops any pending write and any partial frame.

## Structure
- Package frame_capture_pkg holds typedef enum state_t {SEEK, CAPTURE} and constant ERR_COUNT_BITS = 8.
- Sub-module fc_write_buffer: a one-entry register slice with ports load, addr/data in, wr_* out and a ready output. It owns wr_en and the in_ready expression.
- Top level holds the FSM, the position and line_base counters, the checks and the error counter.

## Test plan
Use WIDTH=4, HEIGHT=3.
- Clean frame: 12 beats of data 0..11, sof on beat 0, eol on beats 3/7/11, wr_ready=1. Expect writes addr=data 0..11, frame_done on beat 11, state SEEK, err_count 0.
- Seek: 3 beats with sof=0, then a clean frame. Expect the first 3 beats accepted and not written, then writes starting at addr 0.
- Early eol: eol on beat 2 of line 0. Expect err_line pulse; beats 0..2 written at addr 0..2; the next beat at addr 4; frame_done after 11 accepted beats.
- Mid-frame sof: 6 beats, then a beat with sof=1. Expect err_sof pulse, that beat written at addr 0, cur_x=1, cur_y=0.
- Back-pressure: wr_ready low for 3 cycles with in_valid high. Expect in_ready low while wr_en is high, wr_addr/wr_data held, no beat lost, then full rate resumes.
- Reset mid-frame: rst_n low for 1 cycle at position (2,1) with wr_en high. Expect all reset values, including wr_en 0, and the block in SEEK.
